snn_layer: RTL and testbench
============================

SNN_LAYER -- requirements
Module: snn_layer

Interface
REQ-001 Parameters SHALL be: N_IN 3, input channel count (1..16); N_OUT 4, output neuron count (1..16); W_WIDTH 8, signed weight width; V_WIDTH 16, signed membrane width; THRESH 100, firing threshold; LEAK 1, per-step leak; REFRACT 2, refractory steps after a spike.
REQ-002 clk  in  1  single clock; all logic is on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 in_valid  in  1  the time-step input vector is valid.
REQ-005 in_spike  in  N_IN  input spikes for one time step.
REQ-006 in_ready  out  1  the layer can accept a time step.
REQ-007 out_valid  out  1  the output vector is valid.
REQ-008 out_ready  in  1  the consumer accepts the output.
REQ-009 out_spike  out  N_OUT  output spikes for the step.
REQ-010 out_delay  out  4*N_OUT  per-neuron steps since its last spike, neuron j at bits [4j+3:4j].
REQ-011 w_we, w_in_idx($clog2 N_IN), w_out_idx($clog2 N_OUT), w_data(W_WIDTH)  in  weight write port.

Function
REQ-012 The FSM SHALL have states IDLE, ACCUM and OUT; in_ready SHALL equal (state==IDLE).
REQ-013 IDLE->ACCUM SHALL occur on in_valid&&in_ready; in_spike SHALL be registered on that edge.
REQ-014 ACCUM SHALL run exactly N_IN cycles; in cycle k every neuron j with refr[j]==0 adds weight[k][j] if in_spike[k]==1.
REQ-015 On the last ACCUM cycle each neuron SHALL compute v = max(0, v_acc - LEAK); it fires if v >= THRESH and refr==0.
REQ-016 On firing, v SHALL be set to 0, refr SHALL be set to REFRACT and out_delay[j] SHALL be set to 0; otherwise out_delay[j] SHALL increment and saturate at 15, and refr SHALL decrement if nonzero.
REQ-017 out_valid SHALL assert N_IN+1 cycles after acceptance and hold, with out_spike and out_delay stable, until out_valid&&out_ready; OUT->IDLE follows.
REQ-018 Membrane addition SHALL saturate at 2^(V_WIDTH-1)-1; negative sums SHALL clamp to 0.
REQ-019 w_we SHALL write weight[w_in_idx][w_out_idx] only in IDLE; writes in ACCUM or OUT SHALL be ignored, and out-of-range indices SHALL be ignored.
REQ-020 If w_we and an accepted in_valid occur in the same IDLE cycle, the write SHALL take effect before the accumulation.

Reset
REQ-021 On reset low at a clock edge, the following SHALL be reset: state=IDLE, all v=0, refr=0, out_delay=15, weights=0, out_valid=0, out_spike=0.
REQ-022 A reset asserted mid-ACCUM or mid-OUT SHALL abandon the step with no output handshake.

Configuration
REQ-023 With SNN_STDP_EN defined, a neuron firing in a step SHALL change weight[i][j] by +1 if in_spike[i] was set and by -1 otherwise, saturating at the signed W_WIDTH limits, applied on the OUT entry edge. Without the macro, weights SHALL change only via the write port.

Structure
REQ-024 Package snn_pkg SHALL hold the FSM state enum, the delay width constant (4) and the saturation helper functions.
REQ-025 One sub-module, snn_lif_neuron, SHALL hold the membrane, refractory counter and delay counter; it is instantiated N_OUT times.

Verification
REQ-026 Write weight[0][0]=60, then present in_spike=3'b001 twice -> step 1 out_spike[0]=0 (v=59); step 2 out_spike[0]=1, out_delay[0]=0.
REQ-027 out_ready held low for 5 cycles -> out_valid and outputs stay stable, in_ready=0, and a new in_valid is not accepted.
REQ-028 Weight 127 on a spiking input over 5 steps with REFRACT=2 -> spikes at steps 1 and 4 only, and out_delay counts 0,1,2,0,1.
REQ-029 Reset pulsed during the 2nd ACCUM cycle -> next cycle in_ready=1, out_valid=0, all v=0.
REQ-030 Negative weight -128 with default widths -> v stays 0; 20 idle steps -> out_delay saturates at 15.
REQ-031 SNN_STDP_EN with weight[0][0]=100, weight[1][0]=5 and in_spike=3'b001 causing a fire -> weights become 101 and 4.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking neural network layer:
// FSM state encoding, delay-counter width and saturating arithmetic.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Width of each per-neuron "steps since last spike" counter.
  localparam int DELAY_W   = 4;
  localparam int DELAY_MAX = (1 << DELAY_W) - 1;

  // Clamp a value into [lo, hi].
  function automatic int clamp(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  // Increment a delay counter, holding at its maximum.
  function automatic logic [DELAY_W-1:0] delay_inc(input logic [DELAY_W-1:0] d);
    return (d == DELAY_W'(DELAY_MAX)) ? d : d + 1'b1;
  endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// Leaky integrate-and-fire neuron: membrane potential, refractory counter
// and steps-since-last-spike counter. Accumulates one weight per ACCUM
// cycle; the last ACCUM cycle applies the leak and decides firing.
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int W_WIDTH = 8,
  parameter int V_WIDTH = 16,
  parameter int THRESH  = 100,
  parameter int LEAK    = 1,
  parameter int REFRACT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      accum,
  input  logic                      last,
  input  logic                      in_bit,
  input  logic signed [W_WIDTH-1:0] weight,
  output logic                      fire,
  output logic [DELAY_W-1:0]        delay
);

  localparam int V_MAX = (1 << (V_WIDTH - 1)) - 1;
  localparam int R_W   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  logic signed [V_WIDTH-1:0] v;
  logic [R_W-1:0]            refr;
  logic                      add;
  int                        sum;
  int                        leaked;

  // Saturating accumulate, leak and fire decision for the current cycle.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    add    = accum && in_bit && (refr == '0);
    sum    = add ? clamp(int'(v) + int'(weight), 0, V_MAX) : int'(v);
    leaked = clamp(sum - LEAK, 0, V_MAX);
    fire   = accum && last && (refr == '0) && (leaked >= THRESH);
  end

  // Membrane, refractory and delay state update.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!reset) begin
      v     <= '0;
      refr  <= '0;
      delay <= DELAY_W'(DELAY_MAX);
    end else if (accum) begin
      if (!last) begin
        v <= V_WIDTH'(sum);
      end else if (fire) begin
        v     <= '0;
        refr  <= R_W'(REFRACT);
        delay <= '0;
      end else begin
        v     <= V_WIDTH'(leaked);
        delay <= delay_inc(delay);
        if (refr != '0) refr <= refr - 1'b1;
      end
    end
  end

endmodule

// File: rtl/snn_layer.sv
// Fully connected spiking layer: N_IN input spikes per time step drive
// N_OUT LIF neurons through a writable weight matrix. One step is
// accepted in IDLE, accumulated over N_IN ACCUM cycles (one input per
// cycle) and presented in OUT until the consumer takes it.
// Optional feature: define SNN_STDP_EN to enable a simple +1/-1 weight
// update for every neuron that fires, applied on entry to OUT.
module snn_layer
  import snn_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int N_OUT   = 4,
  parameter int W_WIDTH = 8,
  parameter int V_WIDTH = 16,
  parameter int THRESH  = 100,
  parameter int LEAK    = 1,
  parameter int REFRACT = 2,
  localparam int IW     = (N_IN  > 1) ? $clog2(N_IN)  : 1,
  localparam int OW     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [N_IN-1:0]            in_spike,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT-1:0]           out_spike,
  output logic [DELAY_W*N_OUT-1:0]   out_delay,
  input  logic                       w_we,
  input  logic [IW-1:0]              w_in_idx,
  input  logic [OW-1:0]              w_out_idx,
  input  logic signed [W_WIDTH-1:0]  w_data
);

  state_t                    state_q, state_d;
  logic [IW-1:0]             k;
  logic [N_IN-1:0]           spike_r;
  logic signed [W_WIDTH-1:0] w_mem [N_IN][N_OUT];
  logic                      accum;
  logic                      last;
  logic [N_OUT-1:0]          fire;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign accum     = (state_q == ACCUM);
  assign last      = accum && (k == IW'(N_IN - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = ACCUM;
      ACCUM:   if (last)      state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Capture the step's input spikes, walk the input index, latch the spike vector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      k         <= '0;
      spike_r   <= '0;
      out_spike <= '0;
    end else begin
      if (in_ready && in_valid) begin
        spike_r <= in_spike;
        k       <= '0;
      end else if (accum && !last) begin
        k <= k + 1'b1;
      end
      if (last) out_spike <= fire;
    end
  end

  // Weight matrix: host writes in IDLE only, optional STDP on OUT entry.
  always_ff @(posedge clk) begin
    // NOTE: the weight array is small and must start from zero, so it is reset like ordinary flops.
    if (!reset) begin
      for (int i = 0; i < N_IN; i++)
        for (int j = 0; j < N_OUT; j++)
          w_mem[i][j] <= '0;
    end else if (state_q == IDLE) begin
      if (w_we && (int'(w_in_idx) < N_IN) && (int'(w_out_idx) < N_OUT))
        w_mem[w_in_idx][w_out_idx] <= w_data;
    end
`ifdef SNN_STDP_EN
    else if (last) begin
      for (int i = 0; i < N_IN; i++)
        for (int j = 0; j < N_OUT; j++)
          if (fire[j])
            w_mem[i][j] <= W_WIDTH'(clamp(int'(w_mem[i][j]) + (spike_r[i] ? 1 : -1),
                                          -(1 << (W_WIDTH - 1)), (1 << (W_WIDTH - 1)) - 1));
    end
`endif
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    snn_lif_neuron #(
      .W_WIDTH (W_WIDTH),
      .V_WIDTH (V_WIDTH),
      .THRESH  (THRESH),
      .LEAK    (LEAK),
      .REFRACT (REFRACT)
    ) u_neuron (
      .clk    (clk),
      .reset  (reset),
      .accum  (accum),
      .last   (last),
      .in_bit (spike_r[k]),
      .weight (w_mem[k][j]),
      .fire   (fire[j]),
      .delay  (out_delay[DELAY_W*j +: DELAY_W])
    );
  end

endmodule

// File: tb/tb_snn_layer.sv
// Scoreboard bench for snn_layer: stimulus pushes the hand-computed
// expected spike/delay vector per step, a monitor pops and compares on
// every output handshake.
module tb_snn_layer;

  localparam int N_IN  = 3;
  localparam int N_OUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [N_IN-1:0]   in_spike;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_spike;
  logic [4*N_OUT-1:0] out_delay;
  logic              w_we;
  logic [1:0]        w_in_idx;
  logic [1:0]        w_out_idx;
  logic [7:0]        w_data;

  always #5 clk = ~clk;

  snn_layer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_spike  (in_spike),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_spike (out_spike),
    .out_delay (out_delay),
    .w_we      (w_we),
    .w_in_idx  (w_in_idx),
    .w_out_idx (w_out_idx),
    .w_data    (w_data)
  );

  typedef struct {
    logic [3:0]  spike;
    logic [15:0] delay;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_spike", 32'(out_spike), 32'(e.spike));
        check("out_delay", 32'(out_delay), 32'(e.delay));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic write_w(input int i, input int j, input logic [7:0] d);
    @(posedge clk); #1;
    w_we = 1'b1; w_in_idx = 2'(i); w_out_idx = 2'(j); w_data = d;
    @(posedge clk); #1 w_we = 1'b0;
  endtask

  // mode 0: plain step; 1: attempt weight write w[0][3] during ACCUM;
  // 2: write w[0][2]=127 in the accepting cycle; 3: hold out_ready low 5 cycles.
  task automatic step(input logic [2:0] spk, input logic [3:0] es, input logic [15:0] ed, input int mode);
    exp_t e;
    int   lat;
    bit   ok;
    bit   seen;
    e.spike = es; e.delay = ed;
    sb.push_back(e);
    @(posedge clk); #1;
    if (mode == 3) out_ready = 1'b0;
    in_valid = 1'b1; in_spike = spk;
    if (mode == 2) begin
      w_we = 1'b1; w_in_idx = 2'd0; w_out_idx = 2'd2; w_data = 8'h7f;
    end
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); ok = in_ready;
    end
    check("accepted", 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; w_we = 1'b0;
    if (mode == 1) begin
      w_we = 1'b1; w_in_idx = 2'd0; w_out_idx = 2'd3; w_data = 8'h7f;
    end
    lat = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      lat++;
      seen = out_valid;
      if (lat == 2) w_we = 1'b0;
    end
    w_we = 1'b0;
    check("out_valid_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(N_IN + 1));
    if (mode == 3) begin
      for (int c = 0; c < 5; c++) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_spike", 32'(out_spike), 32'(es));
        check("hold_delay", 32'(out_delay), 32'(ed));
        check("hold_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_spike = 3'b001;
        @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  logic [3:0]  t3_s [5] = '{4'b0001, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
  logic [15:0] t3_d [5] = '{16'hFFF0, 16'hF0F1, 16'hF1F2, 16'hF2F0, 16'hF3F1};

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_spike = '0; out_ready = 1'b1;
    w_we = 1'b0; w_in_idx = '0; w_out_idx = '0; w_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_spike", 32'(out_spike), 32'd0);
    check("rst_out_delay", 32'(out_delay), 32'hFFFF);

`ifdef SNN_STDP_EN
    write_w(0, 0, 8'd100);
    write_w(1, 0, 8'd5);
    step(3'b001, 4'b0000, 16'hFFFF, 0);
    step(3'b001, 4'b0001, 16'hFFF0, 0);
    check("stdp_w00", {24'd0, dut.w_mem[0][0]}, 32'd101);
    check("stdp_w10", {24'd0, dut.w_mem[1][0]}, 32'd4);
    check("stdp_w20", {24'd0, dut.w_mem[2][0]}, 32'hFF);
`else
    // Threshold crossing over two steps.
    write_w(0, 0, 8'd60);
    step(3'b001, 4'b0000, 16'hFFFF, 0);
    check("v0_step1", 32'(dut.g_neuron[0].u_neuron.v), 32'd59);
    step(3'b001, 4'b0001, 16'hFFF0, 0);
    check("v0_after_fire", 32'(dut.g_neuron[0].u_neuron.v), 32'd0);

    // Back-pressure: outputs stable, no new acceptance.
    step(3'b000, 4'b0000, 16'hFFF1, 3);
    check("idle_after_hold", 32'(in_ready), 32'd1);

    // Refractory behaviour with two active neurons.
    do_reset();
    write_w(0, 0, 8'h7f);
    write_w(2, 2, 8'd60);
    write_w(1, 2, 8'd50);
    for (int s = 0; s < 5; s++) step(3'b101, t3_s[s], t3_d[s], 0);

    // Negative clamp, ignored ACCUM write, delay saturation, same-cycle write.
    do_reset();
    write_w(0, 0, 8'h7f);
    write_w(0, 1, 8'h80);
    step(3'b001, 4'b0001, 16'hFFF0, 1);
    check("v1_clamped", 32'(dut.g_neuron[1].u_neuron.v), 32'd0);
    for (int s = 1; s <= 20; s++)
      step(3'b000, 4'b0000, {12'hFFF, 4'((s > 15) ? 15 : s)}, 0);
    step(3'b001, 4'b0101, 16'hF0F0, 2);

    // Reset in the middle of accumulation.
    do_reset();
    write_w(0, 0, 8'd60);
    @(posedge clk); #1 in_valid = 1'b1; in_spike = 3'b001;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check("v0_mid_accum", 32'(dut.g_neuron[0].u_neuron.v), 32'd60);
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_v0", 32'(dut.g_neuron[0].u_neuron.v), 32'd0);
    check("midrst_v2", 32'(dut.g_neuron[2].u_neuron.v), 32'd0);
    step(3'b001, 4'b0000, 16'hFFFF, 0);
`endif

    repeat (6) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
